// File: rtl/debounce_pkg.sv
// Shared state encodings and default parameters for the button debouncer.
// Pure declarations: no latency, no flow control.
package debounce_pkg;

  localparam int DB_CYCLES_DEF  = 4;
  localparam int CNT_W_DEF      = 16;
  localparam int RPT_DELAY_DEF  = 50000;
  localparam int RPT_PERIOD_DEF = 10000;
  localparam int RPT_W_DEF      = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM_HI  = 2'd1,
    PRESSED = 2'd2,
    ARM_LO  = 2'd3
  } db_state_t;

  function automatic logic is_arming(db_state_t s);
    return (s == ARM_HI) || (s == ARM_LO);
  endfunction

endpackage

// File: rtl/debounce_pulse_if.sv
// Button-side bundle: raw level in, press pulse / debounced level / busy out.
// Combinational wiring only; no handshake, the button cannot be stalled.
interface debounce_pulse_if;
  logic BTN_IN;
  logic EN;
  logic LEVEL;
  logic BUSY;

  modport master (output BTN_IN, input EN, input LEVEL, input BUSY);
  modport slave  (input BTN_IN, output EN, output LEVEL, output BUSY);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset value 0.
// Latency 2 cycles; no backpressure.
module sync_2ff (
  input  logic CLK,
  input  logic RST_N,
  input  logic D,
  output logic Q
);

  logic meta;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta <= 1'b0;
      Q    <= 1'b0;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_pulse.sv
// Button debouncer: one-cycle EN per accepted press, optional auto-repeat under DEBOUNCE_AUTOREPEAT_EN.
// EN/LEVEL rise DB_CYCLES+1 cycles after BTN_IN is first sampled high; no backpressure.
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_PERIOD = RPT_PERIOD_DEF,
  parameter int RPT_W      = RPT_W_DEF
) (
  input  logic            CLK,
  input  logic            RST_N,
  debounce_pulse_if.slave btn
);

  if (DB_CYCLES < 2 || CNT_W < $clog2(DB_CYCLES + 1)) begin : g_bad_db
    $error("debounce_pulse: DB_CYCLES must be >= 2 and representable in CNT_W");
  end
  if (RPT_DELAY < 2 || RPT_PERIOD < 2 || RPT_W < $clog2(RPT_DELAY) || RPT_W < $clog2(RPT_PERIOD)) begin : g_bad_rpt
    $error("debounce_pulse: repeat timing must be >= 2 cycles and fit in RPT_W");
  end

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DB_CYCLES);

  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             en_q, level_q, level_nxt;
  logic             accept;
  logic             rpt_fire;
  logic             btn_s;

  sync_2ff u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .D     (btn.BTN_IN),
    .Q     (btn_s)
  );

  // The sample that brings cnt to DB_CYCLES is the accepting one, so the
  // transition fires while cnt still holds DB_CYCLES-1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level_q;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        level_nxt = 1'b0;
        if (btn_s) begin
          state_nxt = ARM_HI;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      ARM_HI: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = CNT_SAT;
          level_nxt = 1'b1;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        level_nxt = 1'b1;
        if (!btn_s) begin
          state_nxt = ARM_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      ARM_LO: begin
        if (btn_s) begin
          state_nxt = PRESSED;
        end else if (cnt >= CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      cnt     <= '0;
      en_q    <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      en_q    <= accept | rpt_fire;
      level_q <= level_nxt;
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(RPT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(RPT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nxt;
  logic             rpt_phase, rpt_phase_nxt;

  // rpt_phase=0 waits out the initial delay, rpt_phase=1 paces later repeats;
  // any exit from PRESSED drops back to the initial delay.
  always_comb begin
    rpt_cnt_nxt   = '0;
    rpt_phase_nxt = 1'b0;
    rpt_fire      = 1'b0;
    if (state == PRESSED && state_nxt == PRESSED) begin
      if (rpt_cnt == (rpt_phase ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
        rpt_fire      = 1'b1;
        rpt_phase_nxt = 1'b1;
      end else begin
        rpt_cnt_nxt   = rpt_cnt + 1'b1;
        rpt_phase_nxt = rpt_phase;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else begin
      rpt_cnt   <= rpt_cnt_nxt;
      rpt_phase <= rpt_phase_nxt;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign btn.EN    = en_q;
  assign btn.LEVEL = level_q;
  assign btn.BUSY  = is_arming(state);

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench for debounce_pulse: vector table plus reset, re-arm and counter sequences.
module tb_debounce_pulse;
  import debounce_pkg::*;

  localparam int DB = 4;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  debounce_pulse_if bif ();

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam bit AUTORPT = 1'b1;
  debounce_pulse #(.DB_CYCLES(DB), .CNT_W(4), .RPT_DELAY(10), .RPT_PERIOD(3), .RPT_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .btn(bif)
  );
`else
  localparam bit AUTORPT = 1'b0;
  debounce_pulse #(.DB_CYCLES(DB), .CNT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .btn(bif)
  );
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Downstream 8-bit counter driven by EN.
  logic [7:0] ctr;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ctr <= 8'd0;
    else if (bif.EN) ctr <= ctr + 8'd1;
  end

  logic en_prev = 1'b0;
  int   en_double = 0;
  always @(negedge CLK) begin
    if (bif.EN && en_prev) en_double++;
    en_prev = bif.EN;
  end

  typedef struct {
    logic btn;
    logic en;
    logic lvl;
    logic busy;
  } vec_t;
  vec_t vq[$];

  function automatic void add(input logic b, input logic e, input logic l, input logic y);
    vec_t v;
    v.btn = b; v.en = e; v.lvl = l; v.busy = y;
    vq.push_back(v);
  endfunction

  // EN expected k cycles after acceptance when auto-repeat is built in (delay 10, period 3).
  function automatic logic rpt_en(input int k);
    return AUTORPT && (k >= 10) && (((k - 10) % 3) == 0);
  endfunction

  task automatic step(input logic b);
    bif.BTN_IN = b;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  bit b_btn  [13] = '{1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0};
  bit b_busy [13] = '{0, 0, 1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0};
  bit g_btn  [7]  = '{0, 0, 1, 1, 1, 1, 1};
  bit g_busy [7]  = '{0, 0, 1, 1, 0, 0, 0};
  bit r_lvl  [7]  = '{1, 1, 1, 1, 1, 0, 0};
  bit r_busy [7]  = '{0, 0, 1, 1, 1, 0, 0};

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    bit found;
    bif.BTN_IN = 1'b0;

    // Clean press held 20 cycles, then release: EN at row 5, LEVEL low at row 25.
    for (int i = 0; i < 28; i++)
      add(i < 20, (i == 5) || (i > 5 && i <= 21 && rpt_en(i - 5)),
          (i >= 5 && i < 25), (i >= 2 && i <= 4) || (i >= 22 && i <= 24));
    for (int i = 0; i < 13; i++) add(b_btn[i], 1'b0, 1'b0, b_busy[i]);
    for (int i = 0; i < 8; i++)
      add(1'b1, i == 5, i >= 5, i >= 2 && i <= 4);
    for (int i = 0; i < 7; i++) add(g_btn[i], 1'b0, 1'b1, g_busy[i]);
    for (int i = 0; i < 7; i++) add(1'b0, 1'b0, r_lvl[i], r_busy[i]);

    repeat (3) @(negedge CLK);
    chk("reset_en", int'(bif.EN), 0);
    chk("reset_level", int'(bif.LEVEL), 0);
    chk("reset_busy", int'(bif.BUSY), 0);
    RST_N = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].btn);
      chk($sformatf("vec%0d_en", i), int'(bif.EN), int'(vq[i].en));
      chk($sformatf("vec%0d_level", i), int'(bif.LEVEL), int'(vq[i].lvl));
      chk($sformatf("vec%0d_busy", i), int'(bif.BUSY), int'(vq[i].busy));
    end
    chk("bounce_end_state", int'(dut.state), int'(IDLE));

    // Reset asserted between edges while arming.
    repeat (3) step(1'b1);
    chk("midarm_busy", int'(bif.BUSY), 1);
    #2 RST_N = 1'b0;
    #1;
    chk("midarm_rst_en", int'(bif.EN), 0);
    chk("midarm_rst_level", int'(bif.LEVEL), 0);
    chk("midarm_rst_busy", int'(bif.BUSY), 0);
    chk("midarm_rst_state", int'(dut.state), int'(IDLE));
    @(negedge CLK);
    RST_N = 1'b1;
    // Button held through release: first sampling edge plus DB+1 more edges.
    edges = 0;
    found = 1'b0;
    while (!found && edges < 20) begin
      step(1'b1);
      edges++;
      if (bif.EN) found = 1'b1;
    end
    chk("rearm_edges_to_en", edges, DB + 2);
    step(1'b1);
    chk("rearm_en_single", int'(bif.EN), 0);
    chk("rearm_level", int'(bif.LEVEL), 1);
    repeat (8) step(1'b0);
    chk("rearm_release_level", int'(bif.LEVEL), 0);

`ifdef DEBOUNCE_AUTOREPEAT_EN
    edges = 0;
    found = 1'b0;
    while (!found && edges < 20) begin
      step(1'b1);
      edges++;
      if (bif.EN) found = 1'b1;
    end
    chk("rpt_accept_edges", edges, DB + 1);
    for (int k = 1; k <= 30; k++) begin
      step(1'b1);
      chk($sformatf("rpt_k%0d_en", k), int'(bif.EN), int'(rpt_en(k)));
    end
    repeat (8) step(1'b0);
`endif

    // Eight bouncy presses into the 8-bit counter.
    RST_N = 1'b0;
    @(negedge CLK);
    chk("ctr_reset", int'(ctr), 0);
    RST_N = 1'b1;
    for (int p = 0; p < 8; p++) begin
      for (int j = 0; j < 6; j++) step(j % 2 == 0);
      repeat (10) step(1'b1);
      for (int j = 0; j < 6; j++) step(j % 2 == 1);
      repeat (10) step(1'b0);
    end
    chk("ctr_after_8_presses", int'(ctr), 8);
    chk("en_never_back_to_back", en_double, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_pulse.md
DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
- REQ-001: Parameter DB_CYCLES, default 4: number of consecutive identical synchronized samples needed to accept a level change. Legal range is 2 or more.
- REQ-002: Parameter CNT_W, default 16: width of the stability counter. It SHALL be at least clog2(DB_CYCLES+1).
- REQ-003: Parameter RPT_DELAY, default 50000: cycles held before the first auto-repeat pulse. Used only when the macro is defined.
- REQ-004: Parameter RPT_PERIOD, default 10000: cycles between later auto-repeat pulses. Used only when the macro is defined.
- REQ-005: Parameter RPT_W, default 20: width of the repeat counter. Used only when the macro is defined.
- REQ-006: CLK, input, 1 bit: the single clock. All logic SHALL be clocked on its rising edge.
- REQ-007: RST_N, input, 1 bit: reset. It SHALL be asynchronous and active-low.
- REQ-008: BTN_IN, input, 1 bit: raw, bouncing, asynchronous button level.
- REQ-009: EN, output, 1 bit: single-cycle press pulse. It SHALL drive the EN input of the downstream Counter directly.
- REQ-010: LEVEL, output, 1 bit: debounced button level.
- REQ-011: BUSY, output, 1 bit: high while the FSM is in state ARM_HI or ARM_LO.

Function
- REQ-012: BTN_IN SHALL pass through a 2-flop synchronizer to produce btn_s, with 2 cycles of latency.
- REQ-013: The FSM SHALL have exactly four states: IDLE, ARM_HI, PRESSED, ARM_LO.
- REQ-014: IDLE: when btn_s=1, go to ARM_HI and load cnt=1.
- REQ-015: ARM_HI: when btn_s=1 and cnt<DB_CYCLES, increment cnt. When cnt reaches DB_CYCLES, go to PRESSED.
- REQ-016: ARM_HI: when btn_s=0, return to IDLE, clear cnt and emit no pulse.
- REQ-017: Entering PRESSED SHALL set LEVEL=1 and assert EN for exactly one cycle. Both are registered outputs.
- REQ-018: Latency: if BTN_IN is first sampled high at posedge k and then held, EN and LEVEL SHALL rise after posedge k+DB_CYCLES+1.
- REQ-019: PRESSED: when btn_s=0, go to ARM_LO and load cnt=1.
- REQ-020: ARM_LO: when btn_s=0 for DB_CYCLES total samples, go to IDLE and set LEVEL=0. No EN pulse is emitted on release.
- REQ-021: ARM_LO: when btn_s=1, return to PRESSED with LEVEL held at 1 and no new EN pulse.
- REQ-022: cnt SHALL saturate at DB_CYCLES and never wrap.
- REQ-023: EN SHALL never be high on two consecutive cycles.
- REQ-024: Unreachable state encodings SHALL recover to IDLE on the next clock edge.

Reset
- REQ-025: While RST_N=0, the block SHALL immediately (asynchronously) force: state=IDLE, cnt=0, repeat counter=0, both synchronizer flops=0, EN=0, LEVEL=0, BUSY=0.
- REQ-026: Reset asserted in any state SHALL abort that state with no EN pulse.
- REQ-027: After reset release, the button SHALL be treated as released. If BTN_IN is held high through release, a full debounce sequence then produces one EN pulse.

Configuration
- REQ-028: The macro DEBOUNCE_AUTOREPEAT_EN controls auto-repeat.
- REQ-029: With the macro defined:
  - While in PRESSED, the repeat counter counts cycles.
  - After RPT_DELAY cycles in PRESSED, EN pulses once.
  - EN then pulses every RPT_PERIOD cycles while the FSM stays in PRESSED.
  - Entering ARM_LO clears the repeat counter; returning to PRESSED restarts the RPT_DELAY wait.
- REQ-030: With the macro undefined, there SHALL be no repeat counter logic and exactly one EN pulse per accepted press. RPT_* parameters are ignored.

Structure
- REQ-031: Package debounce_pkg SHALL hold the state encodings (IDLE=2'd0, ARM_HI=2'd1, PRESSED=2'd2, ARM_LO=2'd3) and the default parameter constants.
- REQ-032: The 2-flop synchronizer SHALL be a sub-module named sync_2ff, with ports CLK, RST_N, D, Q and a reset value of 0.
- REQ-033: The FSM, the counters and the output registers SHALL stay in debounce_pulse.

Verification
All scenarios use DB_CYCLES=4 unless stated otherwise.
- REQ-034: Clean press: BTN_IN goes high at posedge 10 and is held 20 cycles. Required: exactly one EN pulse after posedge 15, LEVEL=1 from the same cycle. On release, LEVEL falls 5 cycles later with no EN.
- REQ-035: Bounce: BTN_IN pattern 1,1,0,0,1,0,1,1,0 and then 0. Required: EN never asserts, LEVEL stays 0, state ends in IDLE, BUSY pulses during each arm attempt.
- REQ-036: Release glitch: while in PRESSED, BTN_IN goes low for 2 cycles and then returns high. Required: LEVEL stays 1 and no second EN pulse.
- REQ-037: Reset mid-arm: RST_N goes low in ARM_HI, between clock edges. Required: all outputs are 0 before the next edge. Release with BTN_IN high gives EN after 5 cycles.
- REQ-038: Auto-repeat: macro defined, RPT_DELAY=10, RPT_PERIOD=3, BTN_IN held 30 cycles after press acceptance. Required: EN at acceptance, then at +10, +13, +16, +19, +22, +25, +28.
- REQ-039: Integration: debounce_pulse feeds a Counter with WIDTH=8; apply 8 clean presses, each with 6-cycle bounce. Required: ctr=8.
